// File: rtl/bnn_image_loader_if.sv
// Byte-stream input and frame output bundle for the BNN image loader.
// The master side is the byte source plus the frame consumer; the slave side is the loader.
interface bnn_image_loader_if #(
  parameter int IMG_SIZE = 30
);
  localparam int IMG_BITS  = IMG_SIZE * IMG_SIZE;
  localparam int NUM_BYTES = (IMG_BITS + 7) / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES);

  logic [7:0]          in_data;
  logic                in_sof;
  logic                in_valid;
  logic                in_ready;
  logic [IMG_BITS-1:0] img;
  logic                img_valid;
  logic                img_ready;
  logic [CNT_W-1:0]    byte_cnt;
  logic                sof_err;

  modport master (
    output in_data, in_sof, in_valid, img_ready,
    input  in_ready, img, img_valid, byte_cnt, sof_err
  );

  modport slave (
    input  in_data, in_sof, in_valid, img_ready,
    output in_ready, img, img_valid, byte_cnt, sof_err
  );
endinterface

// File: rtl/bnn_image_loader.sv
// Assembles an MSB-first byte stream into a flat binary frame and holds it
// stable for the network stage until it is accepted.
module bnn_image_loader #(
  parameter int IMG_SIZE = 30
) (
  input logic              clk,
  input logic              rst_n,
  bnn_image_loader_if.slave bus
);
  localparam int IMG_BITS  = IMG_SIZE * IMG_SIZE;
  localparam int NUM_BYTES = (IMG_BITS + 7) / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES);
  localparam int TAIL_BITS = IMG_BITS - 8 * (NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  typedef enum logic {S_LOAD, S_FULL} state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_img_valid;
  logic                r_sof_err;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [IMG_BITS-1:0] r_img;

  logic                w_accept;
  logic [CNT_W-1:0]    w_idx;

  assign w_accept = bus.in_valid & r_in_ready;
  // A start-of-frame byte always lands in slot 0, whatever the count says.
  assign w_idx    = bus.in_sof ? '0 : r_byte_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_in_ready  <= 1'b1;
      r_img_valid <= 1'b0;
      r_sof_err   <= 1'b0;
      r_byte_cnt  <= '0;
      r_img       <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            if (bus.in_sof && (r_byte_cnt != '0)) r_sof_err <= 1'b1;
            for (int k = 0; k < NUM_BYTES - 1; k++) begin
              if (w_idx == CNT_W'(k)) r_img[IMG_BITS-1-8*k -: 8] <= bus.in_data;
            end
            if (w_idx == LAST_IDX) begin
              // Only the upper bits of the final byte carry pixels.
              r_img[TAIL_BITS-1:0] <= bus.in_data[7 -: TAIL_BITS];
              r_byte_cnt  <= '0;
              r_state     <= S_FULL;
              r_in_ready  <= 1'b0;
              r_img_valid <= 1'b1;
            end else begin
              r_byte_cnt <= w_idx + CNT_W'(1);
            end
          end
        end
        S_FULL: begin
          if (bus.img_ready) begin
            r_state     <= S_LOAD;
            r_in_ready  <= 1'b1;
            r_img_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.img_valid = r_img_valid;
  assign bus.img       = r_img;
  assign bus.byte_cnt  = r_byte_cnt;
  assign bus.sof_err   = r_sof_err;
endmodule

// File: tb/tb_bnn_image_loader.sv
// Testbench for bnn_image_loader: scenario tasks against a pixel-index reference model.
module tb_bnn_image_loader;
  localparam int IMG_SIZE  = 30;
  localparam int IMG_BITS  = IMG_SIZE * IMG_SIZE;
  localparam int NUM_BYTES = (IMG_BITS + 7) / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bnn_image_loader_if #(.IMG_SIZE(IMG_SIZE)) bus ();
  bnn_image_loader #(.IMG_SIZE(IMG_SIZE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  logic [IMG_BITS-1:0] exp_img;
  int                  mk;
  logic                m_sof_err;
  logic                m_done;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic golden_px(int p);
    int r = p / IMG_SIZE;
    int c = p % IMG_SIZE;
    logic outer = (r >= 5) && (r <= 24) && (c >= 8) && (c <= 21);
    logic inner = (r >= 8) && (r <= 21) && (c >= 11) && (c <= 18);
    return outer && !inner;
  endfunction

  function automatic logic [7:0] golden_byte(int k);
    logic [7:0] v = '0;
    for (int b = 0; b < 8; b++)
      if (8 * k + b < IMG_BITS) v[7-b] = golden_px(8 * k + b);
    return v;
  endfunction

  task automatic model_reset();
    exp_img   = '0;
    mk        = 0;
    m_sof_err = 1'b0;
    m_done    = 1'b0;
  endtask

  // Pixel p of the frame is bit IMG_BITS-1-p; byte k carries pixels 8k..8k+7.
  task automatic model_accept(input logic [7:0] d, input logic sof);
    if (sof) begin
      if (mk != 0) m_sof_err = 1'b1;
      mk = 0;
    end
    for (int b = 0; b < 8; b++)
      if (8 * mk + b < IMG_BITS) exp_img[IMG_BITS-1-(8*mk+b)] = d[7-b];
    mk++;
    m_done = 1'b0;
    if (mk == NUM_BYTES) begin
      mk     = 0;
      m_done = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sof);
    int t = 0;
    bus.in_data  = d;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 500) begin
      cyc();
      t++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    cyc();
    model_accept(d, sof);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic consume_frame();
    bus.img_ready = 1'b1;
    cyc();
    bus.img_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_data = '0; bus.in_sof = 1'b0; bus.in_valid = 1'b0; bus.img_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++; if (bus.img_valid !== 1'b0) $display("FAIL rst_img_valid got %b want 0", bus.img_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.byte_cnt !== 7'd0) $display("FAIL rst_byte_cnt got %0d want 0", bus.byte_cnt); else n_pass++;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 50; i++) send_byte(8'($urandom), i == 0);
    n_checks++; if (bus.byte_cnt !== 7'd50) $display("FAIL mid_load_cnt got %0d want 50", bus.byte_cnt); else n_pass++;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.img_valid !== 1'b0) $display("FAIL mid_rst_img_valid got %b want 0", bus.img_valid); else n_pass++;
    n_checks++; if (bus.byte_cnt !== 7'd0) $display("FAIL mid_rst_byte_cnt got %0d want 0", bus.byte_cnt); else n_pass++;
    n_checks++; if (bus.img !== exp_img) $display("FAIL mid_rst_img got %h want %h", bus.img, exp_img); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.sof_err !== 1'b0) $display("FAIL mid_rst_sof_err got %b want 0", bus.sof_err); else n_pass++;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_full_frame();
    logic [IMG_BITS-1:0] g;
    for (int p = 0; p < IMG_BITS; p++) g[IMG_BITS-1-p] = golden_px(p);
    bus.img_ready = 1'b0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (k == NUM_BYTES - 1) begin
        n_checks++; if (bus.img_valid !== 1'b0) $display("FAIL early_img_valid got %b want 0", bus.img_valid); else n_pass++;
      end
      send_byte(golden_byte(k), k == 0);
    end
    n_checks++; if (bus.img_valid !== 1'b1) $display("FAIL latency_img_valid got %b want 1", bus.img_valid); else n_pass++;
    n_checks++; if (bus.img !== g) $display("FAIL golden_img got %h want %h", bus.img, g); else n_pass++;
    n_checks++; if (bus.img !== exp_img) $display("FAIL model_img got %h want %h", bus.img, exp_img); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.byte_cnt !== 7'd0) $display("FAIL full_byte_cnt got %0d want 0", bus.byte_cnt); else n_pass++;
    n_checks++; if (bus.sof_err !== m_sof_err) $display("FAIL full_sof_err got %b want %b", bus.sof_err, m_sof_err); else n_pass++;
  endtask

  task automatic test_hold();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 8'($urandom);
      bus.in_sof  = 1'($urandom % 2);
      cyc();
      n_checks++;
      if (bus.img !== exp_img || bus.byte_cnt !== 7'd0 || bus.in_ready !== 1'b0 || bus.img_valid !== 1'b1)
        $display("FAIL hold_cycle%0d img_ok=%b cnt=%0d in_ready=%b img_valid=%b want img_ok=1 cnt=0 in_ready=0 img_valid=1",
                 i, bus.img === exp_img, bus.byte_cnt, bus.in_ready, bus.img_valid);
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    consume_frame();
    n_checks++; if (bus.img_valid !== 1'b0) $display("FAIL release_img_valid got %b want 0", bus.img_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", bus.in_ready); else n_pass++;
    cyc();
    n_checks++; if (bus.byte_cnt !== 7'(mk)) $display("FAIL release_byte_cnt got %0d want %0d", bus.byte_cnt, mk); else n_pass++;
    n_checks++; if (bus.img !== exp_img) $display("FAIL release_img got %h want %h", bus.img, exp_img); else n_pass++;
  endtask

  task automatic test_resync();
    for (int i = 0; i < 40; i++) send_byte(8'($urandom), i == 0);
    send_byte(8'hFF, 1'b1);
    n_checks++; if (bus.sof_err !== 1'b1) $display("FAIL resync_sof_err got %b want 1", bus.sof_err); else n_pass++;
    n_checks++; if (bus.byte_cnt !== 7'd1) $display("FAIL resync_byte_cnt got %0d want 1", bus.byte_cnt); else n_pass++;
    n_checks++; if (bus.img[IMG_BITS-1 -: 8] !== 8'hFF) $display("FAIL resync_byte0 got %h want ff", bus.img[IMG_BITS-1 -: 8]); else n_pass++;
    for (int i = 0; i < NUM_BYTES - 1; i++) send_byte(8'($urandom), 1'b0);
    n_checks++; if (bus.img_valid !== 1'b1) $display("FAIL resync_img_valid got %b want 1", bus.img_valid); else n_pass++;
    n_checks++; if (bus.img !== exp_img) $display("FAIL resync_img got %h want %h", bus.img, exp_img); else n_pass++;
    consume_frame();
  endtask

  task automatic test_tail();
    for (int k = 0; k < NUM_BYTES; k++)
      send_byte((k == NUM_BYTES - 1) ? 8'hA5 : 8'($urandom), 1'b0);
    n_checks++; if (bus.img[3:0] !== 4'hA) $display("FAIL tail_nibble got %h want a", bus.img[3:0]); else n_pass++;
    n_checks++; if (bus.img !== exp_img) $display("FAIL tail_img got %h want %h", bus.img, exp_img); else n_pass++;
    n_checks++; if (bus.sof_err !== m_sof_err) $display("FAIL tail_sof_err_sticky got %b want %b", bus.sof_err, m_sof_err); else n_pass++;
    consume_frame();
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int   frames = 0, low_cnt = 0, cyc_n = 0, acc_n = 0, errs = 0;
    logic will_acc = 1'b0;
    logic pend = 1'b0;
    logic exp_v;
    for (int i = 0; i < 3 * NUM_BYTES; i++) q.push_back(8'($urandom));
    bus.img_ready = 1'b1;
    bus.in_valid  = 1'b0;
    while (frames < 3 && cyc_n < 20000) begin
      if (!pend) begin
        bus.in_valid = (q.size() > 0) && ($urandom % 2 == 0);
        bus.in_data  = (q.size() > 0) ? q[0] : 8'h00;
        bus.in_sof   = (acc_n % NUM_BYTES) == 0;
      end
      will_acc = bus.in_valid && bus.in_ready;
      cyc();
      cyc_n++;
      if (will_acc) begin
        model_accept(q[0], bus.in_sof);
        void'(q.pop_front());
        acc_n++;
      end
      exp_v = will_acc && m_done;
      if (bus.img_valid !== exp_v || bus.in_ready !== !exp_v || bus.byte_cnt !== 7'(mk)) begin
        if (errs == 0)
          $display("FAIL b2b_cycle%0d img_valid=%b in_ready=%b cnt=%0d want img_valid=%b in_ready=%b cnt=%0d",
                   cyc_n, bus.img_valid, bus.in_ready, bus.byte_cnt, exp_v, !exp_v, mk);
        errs++;
      end
      if (bus.in_ready === 1'b0) low_cnt++;
      if (bus.img_valid === 1'b1) begin
        frames++;
        n_checks++; if (bus.img !== exp_img) $display("FAIL b2b_frame%0d img got %h want %h", frames, bus.img, exp_img); else n_pass++;
      end
      pend = bus.in_valid && !will_acc;
    end
    bus.in_valid  = 1'b0;
    bus.img_ready = 1'b0;
    n_checks++; if (frames != 3) $display("FAIL b2b_frames got %0d want 3", frames); else n_pass++;
    n_checks++; if (errs != 0) $display("FAIL b2b_cycle_errors got %0d want 0", errs); else n_pass++;
    n_checks++; if (low_cnt != 3) $display("FAIL b2b_in_ready_low got %0d want 3", low_cnt); else n_pass++;
    n_checks++; if (q.size() != 0) $display("FAIL b2b_bytes_left got %0d want 0", q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_hold();
    test_resync();
    test_tail();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
